// File: rtl/norm_shift_ctrl_pkg.sv
// Shared constants and state encoding for the FPU add/sub normalization sequencer.
package fpu_norm_pkg;

  localparam int SW  = 26;
  localparam int EW  = 8;
  localparam int SHW = 5;

  localparam logic [EW-1:0] EXP_MAX    = '1;
  localparam int            HIDDEN_BIT = SW - 2;

  typedef enum logic [1:0] {
    IDLE,
    DETECT,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/norm_shift_ctrl_if.sv
// Start/ready request and done/ack result bundle between the add/sub FSM and the normalizer.
interface norm_shift_ctrl_if;
  import fpu_norm_pkg::*;

  logic           start_i;
  logic           ready_o;
  logic [SW-1:0]  sig_i;
  logic [EW-1:0]  exp_i;
  logic           done_o;
  logic           ack_i;
  logic [SW-1:0]  sig_o;
  logic [EW-1:0]  exp_o;
  logic [SHW-1:0] shamt_o;
  logic           zero_o;
  logic           ovf_o;
  logic           unf_o;

  modport master (
    output start_i, sig_i, exp_i, ack_i,
    input  ready_o, done_o, sig_o, exp_o, shamt_o, zero_o, ovf_o, unf_o
  );

  modport slave (
    input  start_i, sig_i, exp_i, ack_i,
    output ready_o, done_o, sig_o, exp_o, shamt_o, zero_o, ovf_o, unf_o
  );

endinterface

// File: rtl/norm_shift_ctrl_lzc.sv
// Combinational leading-zero counter over the hidden bit and fraction bits.
module lzc_sig
  import fpu_norm_pkg::*;
(
  input  logic [SW-2:0]  sig,
  output logic [SHW-1:0] lz,
  output logic           zero
);

  // Ascending scan: the highest set bit is the last one to overwrite lz.
  always_comb begin
    lz   = SHW'(SW - 1);
    zero = 1'b1;
    for (int i = 0; i < SW - 1; i++) begin
      if (sig[i]) begin
        lz   = SHW'(SW - 2 - i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/norm_shift_ctrl.sv
// Normalization sequencer: leading-one detect, shift and exponent adjust after the significand adder.
// Optional build macro NORM_STICKY_EN keeps the bit lost by a right shift as a sticky LSB.
module norm_shift_ctrl
  import fpu_norm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  norm_shift_ctrl_if.slave  bus
);

  state_t state_q, state_d;

  logic [SW-1:0]  sig_p0;
  logic [EW-1:0]  exp_p0;
  logic [SHW-1:0] lz_p1;
  logic           carry_p1;
  logic           allz_p1;

  logic [SHW-1:0] lz_w;
  logic           lzc_zero;

  logic [SW-1:0]  res_sig;
  logic [EW-1:0]  res_exp;
  logic [SHW-1:0] res_sh;
  logic           res_zero, res_ovf, res_unf;

  logic [SW-1:0]  sig_q;
  logic [EW-1:0]  exp_q;
  logic [SHW-1:0] sh_q;
  logic           zero_q, ovf_q, unf_q;

  logic [EW:0]    inc_w;
  logic [SHW-1:0] ush_w;

  function automatic logic [SW-1:0] shr1(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s >> 1;
`ifdef NORM_STICKY_EN
    r[0] = s[1] | s[0];
`else
    r[0] = s[1];
`endif
    return r;
  endfunction

  // Returns {overflow, exponent}; saturates to all-ones when exp+1 would reach it.
  function automatic logic [EW:0] exp_inc_sat(input logic [EW-1:0] e);
    if (e >= EXP_MAX - 1'b1) return {1'b1, EXP_MAX};
    return {1'b0, e + 1'b1};
  endfunction

  lzc_sig u_lzc (
    .sig  (sig_p0[HIDDEN_BIT:0]),
    .lz   (lz_w),
    .zero (lzc_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_i) state_d = DETECT;
      DETECT:  state_d = SHIFT;
      SHIFT:   state_d = DONE;
      DONE:    if (bus.ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // p0: operand capture on the start edge
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.start_i) begin
      sig_p0 <= bus.sig_i;
      exp_p0 <= bus.exp_i;
    end
  end

  // p1: leading-zero count and carry registered in DETECT
  always_ff @(posedge clk) begin
    if (state_q == DETECT) begin
      lz_p1    <= lz_w;
      carry_p1 <= sig_p0[SW-1];
      allz_p1  <= lzc_zero & ~sig_p0[SW-1];
    end
  end

  assign inc_w = exp_inc_sat(exp_p0);
  assign ush_w = SHW'(exp_p0 - 1'b1);

  always_comb begin
    res_sig  = '0;
    res_exp  = '0;
    res_sh   = '0;
    res_zero = 1'b0;
    res_ovf  = 1'b0;
    res_unf  = 1'b0;
    if (allz_p1) begin
      res_zero = 1'b1;
    end else if (carry_p1) begin
      res_exp = inc_w[EW-1:0];
      res_ovf = inc_w[EW];
      if (!inc_w[EW]) res_sig = shr1(sig_p0);
    end else if (exp_p0 > {{(EW-SHW){1'b0}}, lz_p1}) begin
      res_sig = sig_p0 << lz_p1;
      res_exp = exp_p0 - {{(EW-SHW){1'b0}}, lz_p1};
      res_sh  = lz_p1;
    end else begin
      // Underflow: exp <= lz <= 24, so exp-1 always fits the shift width.
      res_unf = 1'b1;
      if (exp_p0 != '0) begin
        res_sig = sig_p0 << ush_w;
        res_sh  = ush_w;
      end else begin
        res_sig = sig_p0;
      end
    end
  end

  // p2: result registers, loaded in SHIFT and held through DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q  <= '0;
      exp_q  <= '0;
      sh_q   <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else if (state_q == SHIFT) begin
      sig_q  <= res_sig;
      exp_q  <= res_exp;
      sh_q   <= res_sh;
      zero_q <= res_zero;
      ovf_q  <= res_ovf;
      unf_q  <= res_unf;
    end
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.done_o  = (state_q == DONE);
  assign bus.sig_o   = sig_q;
  assign bus.exp_o   = exp_q;
  assign bus.shamt_o = sh_q;
  assign bus.zero_o  = zero_q;
  assign bus.ovf_o   = ovf_q;
  assign bus.unf_o   = unf_q;

endmodule

// File: doc/norm_shift_ctrl.md
Name: norm_shift_ctrl

Overview:
Multi-cycle normalization sequencer for the FPU add/subtract datapath; sits after the significand adder and before rounding.
- Accepts the raw 26-bit sum (bit 25 = carry, bit 24 = hidden-bit position) with its exponent.
- Finds the leading one, shifts the significand to normalized position and adjusts the exponent.
- Flags zero, overflow and underflow results.
- Uses a start/ready, done/ack handshake so the add/sub top-level FSM can sequence it.

Parameters:
SW, 26, significand width including the carry bit.
EW, 8, exponent width.
SHW, 5, shift-amount width; must satisfy 2^SHW >= SW.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous active-high reset.
start_i  in  1  request; sampled only while ready_o=1.
ready_o  out  1  high only in IDLE.
sig_i  in  SW  unnormalized significand.
exp_i  in  EW  biased exponent of sig_i.
done_o  out  1  result valid; held until ack_i.
ack_i  in  1  consumer accepts result.
sig_o  out  SW  normalized significand; bit 24 = 1 unless zero or underflow.
exp_o  out  EW  adjusted exponent.
shamt_o  out  SHW  left-shift amount applied (0 for a right shift).
zero_o, ovf_o, unf_o  out  1 each  result flags, valid while done_o=1.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- On rst: state IDLE, ready_o=1, done_o=0; sig_o, exp_o, shamt_o and all flags are 0. Reset mid-operation abandons the operation with no done pulse.
- FSM states: IDLE, DETECT, SHIFT, DONE.
  - IDLE -> DETECT on start_i. sig_i and exp_i are captured in this cycle.
  - DETECT -> SHIFT: register lz = count of zeros from bit 24 downward (0..24) and the carry bit.
  - SHIFT -> DONE: register sig_o, exp_o, shamt_o and the flags.
  - DONE -> IDLE on ack_i.
- Latency: done_o rises 3 clocks after the start edge. ready_o returns the cycle after ack_i.
- start_i outside IDLE is ignored.
- Outputs hold stable throughout DONE.
- ack_i outside DONE is ignored.
- Operation cases, in priority order:
  1. sig==0: zero_o=1, sig_o=0, exp_o=0, shamt_o=0.
  2. sig[25]=1: sig_o=sig>>1, exp_o=exp+1.
     - If exp+1 == all-ones: ovf_o=1, exp_o=all-ones, sig_o=0.
  3. Else if exp > lz: sig_o=sig<<lz, exp_o=exp-lz, shamt_o=lz.
  4. Else (underflow):
     - exp>=1: shift left by exp-1 and set exp_o=0.
     - exp==0: no shift, exp_o=0.
     - unf_o=1 in both cases; shamt_o = shift actually applied.
- lz=0 with no carry means the input is already normal and passes through unchanged.
- Arithmetic is unsigned with no wrap. Subtractions occur only under guards that make them non-negative.
- Flags are mutually exclusive.

Optional Feature:
Macro NORM_STICKY_EN.
- Defined: on a right shift (case 2), sig_o[0] = sig[1] | sig[0], so the lost bit is preserved as sticky.
- Undefined: plain truncation, sig_o[0] = sig[1].
- Left-shift paths are identical either way.

Decomposition:
- Shared package fpu_norm_pkg:
  - state enum {IDLE, DETECT, SHIFT, DONE};
  - constants SW, EW, SHW;
  - constant EXP_MAX = 2^EW-1;
  - localparam HIDDEN_BIT = SW-2.
- One sub-module, lzc_sig: purely combinational leading-zero counter over bits [SW-2:0], outputting lz (SHW bits) and an all-zero flag. It is instantiated in DETECT.
- FSM, shifter and exponent logic stay in norm_shift_ctrl.

Test Plan:
1. sig=26'h0800000, exp=10 -> done at start+3: sig_o=26'h1000000, exp_o=9, shamt_o=1, all flags 0. Hold ack_i low 5 cycles; outputs must stay stable.
2. sig=26'h2000001, exp=5 -> exp_o=6, shamt_o=0. sig_o=26'h1000001 with NORM_STICKY_EN defined, 26'h1000000 without.
3. sig=0, exp=77 -> zero_o=1, sig_o=0, exp_o=0. Separately, sig=26'h1000000, exp=3 -> unchanged, shamt_o=0.
4. sig=26'h0000100 (lz=16), exp=4 -> sig_o=26'h0000800, shamt_o=3, exp_o=0, unf_o=1. Separately, exp=0 -> no shift, unf_o=1.
5. sig=26'h2000000, exp=254 -> ovf_o=1, exp_o=255, sig_o=0. Also pulse start_i while in DETECT: it must be ignored.
6. Assert rst in SHIFT -> next cycle IDLE, ready_o=1, done_o=0, outputs 0. A new start immediately after must complete normally.
